// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, multi-cycle MDU occupancy of EX, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // state    | meaning
  // RUN      | normal issue; branch > mdu_start > load_use evaluated each cycle
  // MDU_WAIT | MDU holds EX; front end frozen until cnt reaches 0
  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 2);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    mdu_busy     = 1'b0;
    if (!reset) begin
      // Hold the pipe in a flushed, NOP-filled state while reset is asserted
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = RUN;
      cnt_nxt      = 8'd0;
    end else if (state == MDU_WAIT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      mdu_busy    = 1'b1;
      if (cnt == 8'd0) state_nxt = RUN;
      else             cnt_nxt   = cnt - 8'd1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mdu_start) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      mdu_busy    = 1'b1;
      state_nxt   = MDU_WAIT;
      cnt_nxt     = MDU_LOAD;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      cnt          <= 8'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stat_clr)
        stall_cycles <= '0;
      else if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int MDU_CYCLES = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_ex_mem_read, if_id_uses_rt, branch_taken, mdu_start, stat_clr;
  logic [4:0]       id_ex_rt, if_id_rs, if_id_rt;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: remaining frozen cycles after an MDU start, and stall count
  int   m_left = 0;
  int   m_cnt  = 0;
  logic e_pc, e_ifw, e_iff, e_idw, e_bub, e_busy;

  pipe_hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .stat_clr(stat_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check just after, then advance the model at posedge.
  task automatic step(input logic br, input logic ms, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic clr);
    logic lu;
    branch_taken = br; mdu_start = ms; id_ex_mem_read = mr; id_ex_rt = ert;
    if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt; stat_clr = clr;
    #1;
    if (!reset) begin m_left = 0; m_cnt = 0; end
    lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    if (!reset)           {e_pc, e_ifw, e_idw, e_iff, e_bub, e_busy} = 6'b001110;
    else if (m_left > 0)  {e_pc, e_ifw, e_idw, e_iff, e_bub, e_busy} = 6'b000001;
    else if (br)          {e_pc, e_ifw, e_idw, e_iff, e_bub, e_busy} = 6'b111110;
    else if (ms)          {e_pc, e_ifw, e_idw, e_iff, e_bub, e_busy} = 6'b000001;
    else if (lu)          {e_pc, e_ifw, e_idw, e_iff, e_bub, e_busy} = 6'b001010;
    else                  {e_pc, e_ifw, e_idw, e_iff, e_bub, e_busy} = 6'b111000;
    chk("pc_write",     32'(pc_write),     32'(e_pc));
    chk("if_id_write",  32'(if_id_write),  32'(e_ifw));
    chk("if_id_flush",  32'(if_id_flush),  32'(e_iff));
    chk("id_ex_write",  32'(id_ex_write),  32'(e_idw));
    chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    chk("mdu_busy",     32'(mdu_busy),     32'(e_busy));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clk);
    if (reset) begin
      if (clr)                          m_cnt = 0;
      else if (!e_pc && m_cnt < CNT_MAX) m_cnt++;
      if (m_left > 0)       m_left--;
      else if (!br && ms)   m_left = MDU_CYCLES - 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    @(negedge clk);
    idle();
    idle();
    reset = 1'b1;
    idle();

    // load-use on rs, then the load moves on
    step(0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    step(0, 0, 0, 5'd5, 5'd5, 5'd0, 0, 0);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // rt gating and r0
    step(0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
    step(0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
    step(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);

    // branch beats mdu_start and load_use
    step(1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 0);
    chk("br_no_mdu", 32'(mdu_busy), 32'd0);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);

    // MDU op; branch at cycle 2 ignored
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    idle();
    chk("mdu_stall_cnt", 32'(stall_cycles), 32'd4);
    chk("mdu_done_pc", 32'(pc_write), 32'd1);

    // reset during MDU_WAIT cycle 2
    step(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    reset = 1'b0;
    idle();
    chk("rst_cnt_zero", 32'(stall_cycles), 32'd0);
    reset = 1'b1;
    idle();

    // saturation and clear while stalled
    for (int i = 0; i < 20; i++) step(0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
    chk("sat_cnt", 32'(stall_cycles), 32'(CNT_MAX));
    step(0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 1);
    step(0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
    chk("clr_then_inc", 32'(stall_cycles), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) reset = 1'b0;
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
